// File: rtl/serial_paralelo_rx_if.sv
// Bus between the serial line stage and the byte receiver.
// The master drives the serial bit; the slave returns the reassembled byte,
// its strobe and the lock flag.
interface serial_paralelo_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Bit-serial to byte receiver.
// Hunts bit by bit for the COM character, then checks byte-aligned COMs until
// ALIGN_COUNT consecutive ones have been seen, after which every byte boundary
// updates data_out and non-COM bytes are flagged with a one-cycle valid_out.
// Lock is only ever released by reset_L.
module serial_paralelo_rx #(
  parameter int          WIDTH       = 8,     // only 8 is supported
  parameter logic [7:0]  COM         = 8'hBC, // alignment / idle character
  parameter int          ALIGN_COUNT = 4      // consecutive COMs for lock, 1..15
) (
  input  logic                clk,
  input  logic                reset_L,
  serial_paralelo_rx_if.slave rx_bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_COUNT);

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [2:0]       r_bit_cnt;
  logic [3:0]       r_bc_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_active;

  // Next-state values
  state_t           w_state_next;
  logic [WIDTH-1:0] w_sr_next;
  logic [2:0]       w_bit_cnt_next;
  logic [3:0]       w_bc_cnt_next;
  logic [WIDTH-1:0] w_data_next;
  logic             w_valid_next;

  // Decodes of the value being shifted in on this edge
  logic             w_is_com;
  logic             w_byte_edge;
  logic [3:0]       w_bc_cnt_inc;
  logic             w_lock_reached;

  // The shift register moves one place per edge; the new bit enters at the LSB
  // so that after eight edges the first (MSB) bit sits at the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sr_next
      if (gi == 0) begin : g_lsb
        assign w_sr_next[gi] = rx_bus.data_in;
      end else begin : g_shift
        assign w_sr_next[gi] = r_sr[gi-1];
      end
    end
  endgenerate

  // All decisions look at the value being loaded, not the stale register,
  // so a match is acted on the same edge that samples its last bit.
  assign w_is_com       = (w_sr_next == COM);
  assign w_byte_edge    = (r_bit_cnt == 3'd7);
  assign w_bc_cnt_inc   = r_bc_cnt + 4'd1;
  assign w_lock_reached = (w_bc_cnt_inc == ALIGN_TARGET);

  // Next-state and datapath decisions for the hunt/align/active sequence
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt + 3'd1;
    w_bc_cnt_next  = r_bc_cnt;
    w_data_next    = r_data;
    w_valid_next   = 1'b0;

    unique case (r_state)
      HUNT: begin
        // Bit-granular search; the counter restarts at the match so the
        // next byte boundary lands eight edges later.
        w_bit_cnt_next = 3'd0;
        if (w_is_com) begin
          w_bc_cnt_next = 4'd1;
          if (ALIGN_TARGET == 4'd1) begin
            w_state_next = ACTIVE;
          end else begin
            w_state_next = ALIGN;
          end
        end else begin
          w_bc_cnt_next = 4'd0;
        end
      end

      ALIGN: begin
        if (w_byte_edge) begin
          if (w_is_com) begin
            w_bc_cnt_next = w_bc_cnt_inc;
            // The byte that completes lock is consumed here and never shown.
            if (w_lock_reached) begin
              w_state_next = ACTIVE;
            end
          end else begin
            // A broken run goes back to hunting from the next edge; this
            // byte itself is not treated as a hunt candidate.
            w_state_next  = HUNT;
            w_bc_cnt_next = 4'd0;
          end
        end
      end

      ACTIVE: begin
        if (w_byte_edge) begin
          // COM bytes are still shown on data_out but are not strobed.
          w_data_next  = w_sr_next;
          w_valid_next = !w_is_com;
        end
      end

      default: begin
        w_state_next   = HUNT;
        w_bit_cnt_next = 3'd0;
        w_bc_cnt_next  = 4'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shift register and alignment counters
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_sr      <= '0;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= 4'd0;
    end else begin
      r_sr      <= w_sr_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bc_cnt  <= w_bc_cnt_next;
    end
  end

  // Registered outputs: byte, strobe and lock flag
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_data   <= w_data_next;
      r_valid  <= w_valid_next;
      r_active <= (w_state_next == ACTIVE);
    end
  end

  assign rx_bus.data_out  = r_data;
  assign rx_bus.valid_out = r_valid;
  assign rx_bus.active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx.
// Two receivers (ALIGN_COUNT 4 and 1) see the same serial stream. Expected
// outputs come from a stream-scanning model over the recorded bit history.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;

  logic clk = 1'b0;
  logic reset_L;

  int checks = 0;
  int errors = 0;

  // Every bit sampled since the last reset, oldest first
  logic bits[$];

  logic       exp4_act, exp4_val, exp1_act, exp1_val;
  logic [7:0] exp4_dat, exp1_dat;

  serial_paralelo_rx_if #(.WIDTH(8)) bus4 ();
  serial_paralelo_rx_if #(.WIDTH(8)) bus1 ();

  serial_paralelo_rx #(.WIDTH(8), .COM(8'hBC), .ALIGN_COUNT(4)) u_dut4 (
    .clk    (clk),
    .reset_L(reset_L),
    .rx_bus (bus4.slave)
  );

  serial_paralelo_rx #(.WIDTH(8), .COM(8'hBC), .ALIGN_COUNT(1)) u_dut1 (
    .clk    (clk),
    .reset_L(reset_L),
    .rx_bus (bus1.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Byte formed by the eight bits ending at index e (bits before reset are 0)
  function automatic logic [7:0] win(input int e);
    logic [7:0] w;
    w = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      int idx;
      idx = e - k;
      w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
    end
    return w;
  endfunction

  // Scan the stream: find a COM anywhere, then look for n_align-1 more COMs at
  // 8-bit spacing; a broken run resumes the search one bit after the bad byte.
  // Once locked, every 8th bit after the lock point is a presented byte.
  function automatic void model(input int n_align, output logic act,
                                output logic val, output logic [7:0] dat);
    int last;
    int e;
    int lock;
    last = bits.size() - 1;
    e    = 0;
    lock = -1;
    act  = 1'b0;
    val  = 1'b0;
    dat  = 8'h00;
    while (e <= last && lock < 0) begin
      if (win(e) == COM) begin
        int run;
        int b;
        run = 1;
        b   = e;
        while (run < n_align && b + 8 <= last && win(b + 8) == COM) begin
          b   = b + 8;
          run = run + 1;
        end
        if (run == n_align) lock = b;
        else if (b + 8 > last) e = last + 1;
        else e = b + 9;
      end else begin
        e = e + 1;
      end
    end
    if (lock >= 0) begin
      int m;
      act = 1'b1;
      m   = (last - lock) / 8;
      if (m >= 1) begin
        int k;
        k   = lock + 8 * m;
        dat = win(k);
        val = (k == last) && (dat != COM);
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    bus4.data_in = b;
    bus1.data_in = b;
    @(posedge clk);
    if (reset_L) bits.push_back(b);
    #1;
    model(4, exp4_act, exp4_val, exp4_dat);
    model(1, exp1_act, exp1_val, exp1_dat);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    bits.delete();
    @(posedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic b;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      b = 1'($urandom_range(0, 1));
      bus4.data_in = b;
      bus1.data_in = b;
      @(posedge clk);
      #1;
      checks++;
      if (bus4.data_out !== 8'h00 || bus4.valid_out !== 1'b0 || bus4.active !== 1'b0 ||
          bus1.active !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got data=%h valid=%b active=%b/%b exp 00 0 0/0",
                 c, bus4.data_out, bus4.valid_out, bus4.active, bus1.active);
      end
    end
    @(posedge clk);
    #2;
    reset_L = 1'b1;
    for (int c = 0; c < 40; c++) begin
      send_bit(1'($urandom_range(0, 1)));
      checks++;
      if (bus4.active !== 1'b0 || bus4.valid_out !== exp4_val) begin
        errors++;
        $display("FAIL post_reset_idle bit=%0d got active=%b valid=%b exp 0 %b",
                 c, bus4.active, bus4.valid_out, exp4_val);
      end
    end
  endtask

  task automatic test_lock_offset();
    logic [7:0] seq [5];
    int idx;
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5};
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    for (int j = 0; j < 5; j++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[j][i]);
        idx = bits.size() - 1;
        checks++;
        if (bus4.active !== (idx >= 34) || bus4.valid_out !== (idx == 42)) begin
          errors++;
          $display("FAIL lock_offset bit=%0d got active=%b valid=%b exp %b %b",
                   idx, bus4.active, bus4.valid_out, idx >= 34, idx == 42);
        end
      end
    end
    checks++;
    if (bus4.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL lock_offset_data got %h exp a5", bus4.data_out);
    end
    send_bit(1'b0);
    checks++;
    if (bus4.valid_out !== 1'b0 || bus4.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL lock_offset_pulse got valid=%b data=%h exp 0 a5",
               bus4.valid_out, bus4.data_out);
    end
  endtask

  task automatic test_broken_preamble();
    logic [7:0] seq [9];
    int idx;
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'h3C, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h5A};
    do_reset();
    for (int j = 0; j < 9; j++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[j][i]);
        idx = bits.size() - 1;
        checks++;
        if (bus4.active !== (idx >= 63) || bus4.valid_out !== (idx == 71)) begin
          errors++;
          $display("FAIL broken_preamble bit=%0d got active=%b valid=%b exp %b %b",
                   idx, bus4.active, bus4.valid_out, idx >= 63, idx == 71);
        end
      end
    end
    checks++;
    if (bus4.data_out !== 8'h5A) begin
      errors++;
      $display("FAIL broken_preamble_data got %h exp 5a", bus4.data_out);
    end
  endtask

  // Runs straight after test_broken_preamble, so the receiver is locked.
  task automatic test_idle_filter();
    logic [7:0] seq [3];
    int base;
    int rel;
    int last_valid;
    seq = '{8'hA5, 8'hBC, 8'h5A};
    base = bits.size();
    last_valid = -1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[j][i]);
        rel = bits.size() - 1 - base;
        checks++;
        if (bus4.active !== 1'b1 || bus4.valid_out !== (rel == 7 || rel == 23)) begin
          errors++;
          $display("FAIL idle_filter rel=%0d got active=%b valid=%b exp 1 %b",
                   rel, bus4.active, bus4.valid_out, rel == 7 || rel == 23);
        end
        if (rel == 7 || rel == 15 || rel == 23) begin
          checks++;
          if (bus4.data_out !== seq[j]) begin
            errors++;
            $display("FAIL idle_filter_data rel=%0d got %h exp %h", rel, bus4.data_out, seq[j]);
          end
        end
        if (bus4.valid_out === 1'b1) begin
          if (last_valid >= 0) begin
            checks++;
            if (rel - last_valid != 16) begin
              errors++;
              $display("FAIL idle_filter_spacing got %0d exp 16", rel - last_valid);
            end
          end
          last_valid = rel;
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] v;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) send_bit(1'($urandom_range(0, 1)));
      for (int j = 0; j < 30; j++) begin
        if (j < 20) v = ($urandom_range(0, 9) < 6) ? COM : 8'($urandom);
        else        v = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          send_bit(v[i]);
          checks++;
          if (bus4.active !== exp4_act || bus4.valid_out !== exp4_val || bus4.data_out !== exp4_dat ||
              bus1.active !== exp1_act || bus1.valid_out !== exp1_val || bus1.data_out !== exp1_dat) begin
            errors++;
            $display("FAIL random_stream it=%0d bit=%0d got n4 %b %b %h n1 %b %b %h exp n4 %b %b %h n1 %b %b %h",
                     it, bits.size() - 1, bus4.active, bus4.valid_out, bus4.data_out,
                     bus1.active, bus1.valid_out, bus1.data_out,
                     exp4_act, exp4_val, exp4_dat, exp1_act, exp1_val, exp1_dat);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] v;
    do_reset();
    v = COM;
    for (int j = 0; j < 4; j++) for (int i = 7; i >= 0; i--) send_bit(v[i]);
    v = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    checks++;
    if (bus4.active !== 1'b1 || bus4.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL midop_prelock got active=%b data=%h exp 1 a5", bus4.active, bus4.data_out);
    end
    v = 8'h66;
    for (int i = 7; i >= 4; i--) send_bit(v[i]);
    #2;
    reset_L = 1'b0;
    bits.delete();
    #1;
    checks++;
    if (bus4.active !== 1'b0 || bus4.valid_out !== 1'b0 || bus4.data_out !== 8'h00) begin
      errors++;
      $display("FAIL midop_async_clear got active=%b valid=%b data=%h exp 0 0 00",
               bus4.active, bus4.valid_out, bus4.data_out);
    end
    @(posedge clk);
    #2;
    reset_L = 1'b1;
    v = 8'h5A;
    for (int j = 0; j < 5; j++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(v[i]);
        checks++;
        if (bus4.active !== 1'b0 || bus4.valid_out !== 1'b0 || bus4.valid_out !== exp4_val) begin
          errors++;
          $display("FAIL midop_relock bit=%0d got active=%b valid=%b exp 0 0",
                   bits.size() - 1, bus4.active, bus4.valid_out);
        end
      end
    end
  endtask

  task automatic test_align_one();
    logic [7:0] seq [2];
    int idx;
    seq = '{8'hBC, 8'h11};
    do_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[j][i]);
        idx = bits.size() - 1;
        checks++;
        if (bus1.active !== (idx >= 7) || bus1.valid_out !== (idx == 15)) begin
          errors++;
          $display("FAIL align_one bit=%0d got active=%b valid=%b exp %b %b",
                   idx, bus1.active, bus1.valid_out, idx >= 7, idx == 15);
        end
      end
    end
    checks++;
    if (bus1.data_out !== 8'h11) begin
      errors++;
      $display("FAIL align_one_data got %h exp 11", bus1.data_out);
    end
  endtask

  initial begin
    bus4.data_in = 1'b0;
    bus1.data_in = 1'b0;
    reset_L = 1'b1;
    #1;
    reset_L = 1'b0;
    test_reset();
    test_lock_offset();
    test_broken_preamble();
    test_idle_filter();
    test_random_stream();
    test_reset_midop();
    test_align_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
